// File: rtl/riscv_run_controller_pkg.sv
// Shared definitions for the RV32I run sequencer: FSM states, error causes
// and the two opcodes that stop the core.
package riscv_run_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PC_INIT = 3'd2,
    ST_RUN     = 3'd3,
    ST_HALT    = 3'd4,
    ST_ERROR   = 3'd5
  } rrc_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_OVERFLOW = 2'b01,
    ERR_MISALIGN = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } rrc_err_e;

  localparam logic [31:0] OPC_ECALL    = 32'h0000_0073;
  localparam logic [31:0] OPC_JAL_SELF = 32'h0000_006F;

  function automatic logic is_halt_opcode(input logic [31:0] instr);
    return (instr == OPC_ECALL) || (instr == OPC_JAL_SELF);
  endfunction

endpackage

// File: rtl/rrc_halt_detect.sv
// Purely combinational stop conditions seen on the core fetch port; zero latency.
module rrc_halt_detect
  import riscv_run_controller_pkg::*;
(
  input  logic [1:0]  pc_lo,
  input  logic [31:0] instr,
  output logic        halt_insn,
  output logic        misaligned
);

  assign halt_insn  = is_halt_opcode(instr);
  assign misaligned = |pc_lo;

endmodule

// File: rtl/riscv_run_controller.sv
// Run sequencer: streams a program into imem (write 1 cycle after acceptance),
// loads the start PC, then gates the core (free-run/step) until halt, error or abort.
module riscv_run_controller
  import riscv_run_controller_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [31:0]      load_data,
  input  logic             load_last,
  input  logic             start,
  input  logic             abort,
  input  logic             step_mode,
  input  logic             step,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             core_start,
  output logic [31:0]      core_init_addr,
  output logic             core_en,
  input  logic [31:0]      core_pc,
  input  logic [31:0]      core_instr,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [31:0]      halt_pc,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned      IDX_W    = $clog2(IMEM_DEPTH + 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(IMEM_DEPTH);
  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  rrc_state_e       state_q, state_d;
  rrc_err_e         err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      halt_pc_q, halt_pc_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;

  logic halt_insn;
  logic misaligned;
  logic timeout_hit;
  logic run_en;

  rrc_halt_detect u_halt_detect (
    .pc_lo      (core_pc[1:0]),
    .instr      (core_instr),
    .halt_insn  (halt_insn),
    .misaligned (misaligned)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cyc_q >= TO_LIM);

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    idx_d      = idx_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    halt_pc_d  = halt_pc_q;
    cyc_d      = cyc_q;
    ins_d      = ins_q;
    load_ready = 1'b0;
    core_en    = 1'b0;
    core_start = 1'b0;
    run_en     = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT, ST_ERROR: begin
        if (start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          cyc_d   = '0;
          ins_d   = '0;
          err_d   = ERR_NONE;
        end
      end

      ST_LOAD: begin
        load_ready = ~abort;
        if (load_valid && !abort) begin
          // The beat one past the end is consumed but never written.
          if (idx_q == IDX_FULL) begin
            state_d   = ST_ERROR;
            err_d     = ERR_OVERFLOW;
            halt_pc_d = core_pc;
          end else begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + (32'(idx_q) << 2);
            wdata_d = load_data;
            idx_d   = idx_q + IDX_W'(1);
            if (load_last) begin
              state_d = ST_PC_INIT;
            end
          end
        end
      end

      ST_PC_INIT: begin
        core_en = ~abort;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        core_start = 1'b1;
        if (abort) begin
          core_en = 1'b0;
        end else if (misaligned) begin
          state_d   = ST_ERROR;
          err_d     = ERR_MISALIGN;
          halt_pc_d = core_pc;
        end else if (halt_insn) begin
          state_d   = ST_HALT;
          halt_pc_d = core_pc;
        end else if (timeout_hit) begin
          state_d   = ST_ERROR;
          err_d     = ERR_TIMEOUT;
          halt_pc_d = core_pc;
        end else begin
          run_en  = ~step_mode | step;
          core_en = run_en;
          if (run_en) begin
            cyc_d = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_W'(1);
            ins_d = (ins_q == CNT_MAX) ? ins_q : ins_q + CNT_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      err_q     <= ERR_NONE;
      idx_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      halt_pc_q <= '0;
      cyc_q     <= '0;
      ins_q     <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      halt_pc_q <= halt_pc_d;
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
    end
  end

  assign imem_we        = we_q;
  assign imem_addr      = addr_q;
  assign imem_wdata     = wdata_q;
  assign core_init_addr = BASE_ADDR;
  assign busy           = (state_q == ST_LOAD) || (state_q == ST_PC_INIT) || (state_q == ST_RUN);
  assign halted         = (state_q == ST_HALT);
  assign error          = (state_q == ST_ERROR);
  assign err_code       = err_q;
  assign halt_pc        = halt_pc_q;
  assign cycle_count    = cyc_q;
  assign instr_count    = ins_q;

endmodule

// File: tb/tb_riscv_run_controller.sv
// Scoreboard bench: a tiny RV32I subset core executes what the controller lets it,
// and an ISA-level model predicts imem writes and the final stop record.
module tb_riscv_run_controller;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned TMO   = 24;
  localparam int unsigned CW    = 16;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] JSELF = 32'h0000_006F;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct { logic [31:0] pc; logic [31:0] x [4]; } arch_t;
  typedef struct { int kind; logic [1:0] err; logic chk_pc; logic [31:0] pc; int cnt; logic [31:0] x [4]; } end_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0, load_last = 1'b0, start = 1'b0, abort = 1'b0;
  logic          step_mode = 1'b0, step = 1'b0;
  logic [31:0]   load_data = '0;
  logic          load_ready, imem_we, core_start, core_en, busy, halted, error;
  logic [31:0]   imem_addr, imem_wdata, core_init_addr, core_pc, core_instr, halt_pc;
  logic [1:0]    err_code;
  logic [CW-1:0] cycle_count, instr_count;

  always #5 clk = ~clk;

  riscv_run_controller #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_last(load_last), .start(start), .abort(abort), .step_mode(step_mode), .step(step),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_start(core_start),
    .core_init_addr(core_init_addr), .core_en(core_en), .core_pc(core_pc), .core_instr(core_instr),
    .busy(busy), .halted(halted), .error(error), .err_code(err_code), .halt_pc(halt_pc),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12, 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] enc_jal(input int rd, input int off);
    logic [20:0] im;
    im = 21'(off);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6F};
  endfunction

  function automatic arch_t isa_step(input arch_t s, input logic [31:0] ins);
    arch_t n;
    logic [31:0] val;
    logic wr;
    n = s;
    n.pc = s.pc + 32'd4;
    wr = 1'b0;
    val = '0;
    if (ins[6:0] == 7'h13 && ins[14:12] == 3'b000) begin
      wr = 1'b1;
      val = s.x[ins[16:15]] + {{20{ins[31]}}, ins[31:20]};
    end else if (ins[6:0] == 7'h6F) begin
      wr = 1'b1;
      val = s.pc + 32'd4;
      n.pc = s.pc + {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    end
    if (wr && ins[11:7] != 5'd0 && ins[11:7] < 5'd4) n.x[ins[8:7]] = val;
    return n;
  endfunction

  // Environment core: PC and registers move only when the controller enables it.
  logic [31:0] tmem [16];
  arch_t       core_s;
  logic        clr_core = 1'b1;

  assign core_pc    = core_s.pc;
  assign core_instr = tmem[core_s.pc[5:2]];

  always @(posedge clk) begin
    if (imem_we) tmem[imem_addr[5:2]] <= imem_wdata;
    if (clr_core) begin
      core_s.pc <= 32'h80;
      for (int r = 0; r < 4; r++) core_s.x[r] <= '0;
    end else if (core_en) begin
      if (!core_start) core_s.pc <= core_init_addr;
      else core_s <= isa_step(core_s, core_instr);
    end
  end

  logic [31:0] prog [$];
  logic [63:0] wr_q [$];
  end_t        end_q [$];

  // Reference: walk the program at ISA level and record how and where it must stop.
  task automatic predict();
    arch_t s;
    end_t e;
    int cnt, idx;
    logic [31:0] ins;
    bit done;
    for (int i = 0; i < prog.size() && i < int'(DEPTH); i++) wr_q.push_back({BASE + 32'(4 * i), prog[i]});
    s.pc = BASE;
    for (int r = 0; r < 4; r++) s.x[r] = '0;
    e.kind = 0; e.err = 2'b00; e.chk_pc = 1'b1; e.pc = '0;
    cnt = 0; done = 0;
    if (prog.size() > int'(DEPTH)) begin
      e.kind = 2; e.err = 2'b01; e.chk_pc = 1'b0; done = 1;
    end
    for (int guard = 0; !done && guard < 1000; guard++) begin
      idx = int'((s.pc - BASE) >> 2);
      ins = (idx < prog.size()) ? prog[idx] : 32'h0;
      if (s.pc[1:0] != 2'b00) begin e.kind = 2; e.err = 2'b10; done = 1; end
      else if (ins == ECALL || ins == JSELF) begin e.kind = 1; done = 1; end
      else if (TMO != 0 && cnt == int'(TMO)) begin e.kind = 2; e.err = 2'b11; done = 1; end
      else begin s = isa_step(s, ins); cnt++; end
    end
    e.pc = s.pc; e.cnt = cnt; e.x = s.x;
    end_q.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT writes imem or stops.
  logic [63:0] mon_w;
  end_t        mon_e;
  logic        prev_end = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_end = 1'b0;
    end else begin
      if (imem_we) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write", imem_addr, imem_wdata);
        end else begin
          mon_w = wr_q.pop_front();
          check("imem_addr", imem_addr, mon_w[63:32]);
          check("imem_wdata", imem_wdata, mon_w[31:0]);
        end
      end
      if ((halted || error) && !prev_end) begin
        if (end_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_stop: got halted=%0b error=%0b, expected still running", halted, error);
        end else begin
          mon_e = end_q.pop_front();
          check("end_halted", 32'(halted), 32'(mon_e.kind == 1));
          check("end_error", 32'(error), 32'(mon_e.kind == 2));
          check("err_code", 32'(err_code), 32'(mon_e.err));
          if (mon_e.chk_pc) check("halt_pc", halt_pc, mon_e.pc);
          check("instr_count", 32'(instr_count), 32'(mon_e.cnt));
          check("cycle_count", 32'(cycle_count), 32'(mon_e.cnt));
          for (int r = 1; r < 4; r++) check("core_reg", core_s.x[r], mon_e.x[r]);
        end
      end
      prev_end = halted || error;
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("load_entry_busy", 32'(busy), 32'd1);
    check("load_entry_ready", 32'(load_ready), 32'd1);
    check("restart_cycle_count", 32'(cycle_count), 32'd0);
    check("restart_instr_count", 32'(instr_count), 32'd0);
  endtask

  task automatic load_beats(input int nbeats);
    int budget;
    for (int i = 0; i < nbeats; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == prog.size() - 1);
      budget = 0;
      while (!load_ready && budget < 50) begin @(negedge clk); budget++; end
      if (budget == 50) begin
        checks++; errors++;
        $display("FAIL load_ready_wait: got ready=0 for 50 cycles, expected 1");
      end
      @(negedge clk);
      load_valid = 1'b0; load_last = 1'b0;
    end
  endtask

  task automatic wait_run();
    int budget = 0;
    while (!core_start && budget < 100) begin @(negedge clk); budget++; end
    if (budget == 100) begin
      checks++; errors++;
      $display("FAIL wait_run: got core_start=0 for 100 cycles, expected 1");
    end
  endtask

  task automatic run_prog(input bit smode);
    int budget;
    int n_exp;
    clr_core = 1'b1; @(negedge clk); clr_core = 1'b0;
    predict();
    n_exp = end_q[end_q.size() - 1].cnt;
    step_mode = smode;
    pulse_start();
    load_beats(prog.size());
    if (smode && prog.size() <= int'(DEPTH)) begin
      wait_run();
      for (int k = 1; k <= n_exp; k++) begin
        repeat (4) @(negedge clk);
        check("step_hold_count", 32'(instr_count), 32'(k - 1));
        step = 1'b1; @(negedge clk); step = 1'b0;
        repeat (2) @(negedge clk);
        check("step_count", 32'(instr_count), 32'(k));
        check("step_pc", core_pc, BASE + 32'(4 * k));
        check("step_halted", 32'(halted), 32'(k == n_exp));
      end
    end
    budget = 0;
    while (!(halted || error) && budget < 3000) begin @(negedge clk); budget++; end
    if (budget == 3000) begin
      checks++; errors++;
      $display("FAIL wait_stop: got no halt/error in 3000 cycles, expected a stop");
    end
    step_mode = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_core_en", 32'(core_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_init_addr", core_init_addr, BASE);
    rst_n = 1'b1;
    @(negedge clk);

    // addi x1,x0,5; addi x2,x1,3; ecall -- free run, then single-step
    prog = '{enc_addi(1, 0, 5), enc_addi(2, 1, 3), ECALL};
    run_prog(1'b0);
    check("t1_x2", core_s.x[2], 32'd8);
    run_prog(1'b1);

    // One word past the end of imem
    prog.delete();
    for (int i = 0; i < int'(DEPTH) + 1; i++) prog.push_back(enc_addi(1, 1, i + 1));
    run_prog(1'b0);

    // Spinning loop runs into the timeout
    prog = '{NOP, enc_jal(0, -4)};
    run_prog(1'b0);

    // Jump to a non-word-aligned target
    prog = '{enc_addi(1, 0, 7), enc_jal(0, 2)};
    run_prog(1'b0);

    // Last beat exactly at the final imem word
    prog.delete();
    for (int i = 0; i < int'(DEPTH) - 1; i++) prog.push_back(enc_addi(1 + i % 3, i % 4, 3 * i + 1));
    prog.push_back(JSELF);
    run_prog(1'b0);

    // Abort in the fourth RUN cycle
    prog = '{NOP, enc_jal(0, -4)};
    clr_core = 1'b1; @(negedge clk); clr_core = 1'b0;
    wr_q.push_back({BASE, NOP});
    wr_q.push_back({BASE + 32'd4, enc_jal(0, -4)});
    pulse_start();
    load_beats(2);
    wait_run();
    repeat (3) @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort_core_en", 32'(core_en), 32'd0);
    check("abort_cycle_busy", 32'(busy), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_halted", 32'(halted), 32'd0);
    check("abort_idle_error", 32'(error), 32'd0);
    check("abort_hold_count", 32'(instr_count), 32'd3);
    prog = '{enc_addi(1, 0, 5), enc_addi(2, 1, 3), ECALL};
    run_prog(1'b0);

    // Randomized programs in either mode
    for (int t = 0; t < 8; t++) begin
      prog.delete();
      n = $urandom_range(3, DEPTH);
      for (int i = 0; i < n - 1; i++) begin
        if ($urandom_range(0, 5) == 0) prog.push_back(enc_jal(1, 4));
        else prog.push_back(enc_addi($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 4095)));
      end
      prog.push_back(($urandom_range(0, 1) == 1) ? ECALL : JSELF);
      run_prog(1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a load
    prog = '{enc_addi(1, 0, 5), enc_addi(2, 1, 3), ECALL};
    wr_q.push_back({BASE, prog[0]});
    wr_q.push_back({BASE + 32'd4, prog[1]});
    pulse_start();
    load_beats(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(load_ready), 32'd0);
    check("mid_rst_we", 32'(imem_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", imem_addr, 32'd0);
    check("mid_rst_init_addr", core_init_addr, BASE);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_ready", 32'(load_ready), 32'd0);

    check("writes_drained", 32'(wr_q.size()), 32'd0);
    check("stops_drained", 32'(end_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
